// File: rtl/msrv_32_pkg.sv
// Shared MSRV-32 definitions: RV32 opcode[6:2] constants for control-transfer
// instructions and the 2-bit branch direction counter encoding. Used by the
// branch predictor and the branch unit so both agree on opcodes and states.
package msrv_32_pkg;

  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  // Two-bit saturating direction counter; bit 1 is the predicted direction.
  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } bp_ctr_e;

  // Every table entry starts weakly not-taken so one taken outcome flips it.
  localparam bp_ctr_e CTR_RESET = CTR_WEAK_NT;

  // Unconditional jumps are always predicted taken.
  function automatic logic is_jump(input logic [4:0] opc);
    return (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

  // Only conditional branches consult or train the direction table.
  function automatic logic is_branch(input logic [4:0] opc);
    return (opc == OPC_BRANCH);
  endfunction

  // 32-bit event counter increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/msrv_32_branch_predictor_if.sv
// Fetch/branch-unit side bus of the MSRV-32 branch predictor: the lookup
// request from fetch, the flush kill, the resolved-branch update report and
// the registered prediction and mispredict results. The master modport is the
// pipeline driving requests; the slave modport is the predictor itself.
interface msrv_32_branch_predictor_if;

  logic        lookup_valid_in;
  logic [31:0] lookup_pc_in;
  logic [4:0]  lookup_opcode_6_to_2_in;
  logic        flush_in;
  logic        pred_valid_out;
  logic        pred_taken_out;

  logic        upd_valid_in;
  logic [31:0] upd_pc_in;
  logic [4:0]  upd_opcode_6_to_2_in;
  logic        upd_taken_in;
  logic        upd_pred_in;
  logic        mispredict_out;

  modport master (
    output lookup_valid_in,
    output lookup_pc_in,
    output lookup_opcode_6_to_2_in,
    output flush_in,
    output upd_valid_in,
    output upd_pc_in,
    output upd_opcode_6_to_2_in,
    output upd_taken_in,
    output upd_pred_in,
    input  pred_valid_out,
    input  pred_taken_out,
    input  mispredict_out
  );

  modport slave (
    input  lookup_valid_in,
    input  lookup_pc_in,
    input  lookup_opcode_6_to_2_in,
    input  flush_in,
    input  upd_valid_in,
    input  upd_pc_in,
    input  upd_opcode_6_to_2_in,
    input  upd_taken_in,
    input  upd_pred_in,
    output pred_valid_out,
    output pred_taken_out,
    output mispredict_out
  );

endinterface

// File: rtl/msrv_32_sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter: a taken
// outcome moves one step toward strong-taken, a not-taken outcome one step
// toward strong-not-taken, holding at either end.
module msrv_32_sat_counter2
  import msrv_32_pkg::*;
(
  input  bp_ctr_e state_in,
  input  logic    taken_in,
  output bp_ctr_e state_out
);

  // Step the counter one position in the direction of the resolved outcome.
  always_comb begin
    state_out = state_in;
    unique case (state_in)
      CTR_STRONG_NT: state_out = taken_in ? CTR_WEAK_NT  : CTR_STRONG_NT;
      CTR_WEAK_NT:   state_out = taken_in ? CTR_WEAK_T   : CTR_STRONG_NT;
      CTR_WEAK_T:    state_out = taken_in ? CTR_STRONG_T : CTR_WEAK_NT;
      CTR_STRONG_T:  state_out = taken_in ? CTR_STRONG_T : CTR_WEAK_T;
      default:       state_out = state_in;
    endcase
  end

endmodule

// File: rtl/msrv_32_branch_predictor.sv
// MSRV-32 bimodal branch predictor. A table of ENTRIES 2-bit counters is
// indexed by pc[IDX_W+1:2] from both the fetch lookup and the branch-unit
// update. Predictions are registered (one cycle after the lookup); jumps are
// always taken, conditional branches follow the counter MSB, everything else
// is not taken. Lookups read the table before any same-cycle update lands.
// Optional feature: define MSRV32_BP_STATS_EN to add saturating 32-bit
// counters of conditional-branch updates and mispredicting updates.
module msrv_32_branch_predictor
  import msrv_32_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
`ifdef MSRV32_BP_STATS_EN
  output logic [31:0] stat_branches_out,
  output logic [31:0] stat_mispredicts_out,
`endif
  msrv_32_branch_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Direction table and registered outputs.
  bp_ctr_e    table_q [ENTRIES];
  bp_ctr_e    table_d [ENTRIES];
  logic       pred_valid_q, pred_valid_d;
  logic       pred_taken_q, pred_taken_d;
  logic       mispredict_q, mispredict_d;

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] upd_idx;
  bp_ctr_e          lookup_ctr;
  bp_ctr_e          upd_ctr;
  bp_ctr_e          upd_ctr_next;
  logic             lookup_live;
  logic             upd_train;
  logic             upd_wrong;

  // PC bits outside the index field never affect the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc_in[31:IDX_W+2], bus.lookup_pc_in[1:0],
                            bus.upd_pc_in[31:IDX_W+2],    bus.upd_pc_in[1:0]};

  assign lookup_idx  = bus.lookup_pc_in[IDX_W+1:2];
  assign upd_idx     = bus.upd_pc_in[IDX_W+1:2];
  assign lookup_ctr  = table_q[lookup_idx];
  assign upd_ctr     = table_q[upd_idx];
  assign lookup_live = bus.lookup_valid_in & ~bus.flush_in;
  assign upd_train   = bus.upd_valid_in & is_branch(bus.upd_opcode_6_to_2_in);
  assign upd_wrong   = bus.upd_valid_in & (bus.upd_taken_in != bus.upd_pred_in);

  msrv_32_sat_counter2 u_sat_counter2 (
    .state_in  (upd_ctr),
    .taken_in  (bus.upd_taken_in),
    .state_out (upd_ctr_next)
  );

  // Only a resolved conditional branch trains its entry; jumps and other
  // opcodes leave the table untouched, and flush does not block training.
  always_comb begin
    table_d = table_q;
    if (upd_train) begin
      table_d[upd_idx] = upd_ctr_next;
    end
  end

  // Prediction for next cycle, taken from the pre-update table contents so a
  // colliding update is only visible to later lookups.
  always_comb begin
    pred_valid_d = lookup_live;
    pred_taken_d = 1'b0;
    if (lookup_live) begin
      if (is_jump(bus.lookup_opcode_6_to_2_in)) begin
        pred_taken_d = 1'b1;
      end else if (is_branch(bus.lookup_opcode_6_to_2_in)) begin
        pred_taken_d = lookup_ctr[1];
      end
    end
    mispredict_d = upd_wrong;
  end

  // Table and output registers; reset drops any in-flight lookup or update
  // and returns every entry to weakly not-taken.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= CTR_RESET;
      end
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      table_q      <= table_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign bus.pred_valid_out = pred_valid_q;
  assign bus.pred_taken_out = pred_taken_q;
  assign bus.mispredict_out = mispredict_q;

`ifdef MSRV32_BP_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Count conditional-branch updates and mispredicting updates, sticking at
  // all-ones instead of wrapping.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_train) begin
      stat_branches_d = sat_inc32(stat_branches_q);
    end
    if (upd_wrong) begin
      stat_mispredicts_d = sat_inc32(stat_mispredicts_q);
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stat_branches_q    <= 32'd0;
      stat_mispredicts_q <= 32'd0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches_out    = stat_branches_q;
  assign stat_mispredicts_out = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_msrv_32_branch_predictor.sv
// Self-checking bench for msrv_32_branch_predictor: directed scenarios for
// reset, training, saturation, jumps, read-before-write, mispredict, flush
// and mid-stream reset, followed by a randomized run. Expected results come
// from a table of integer counters updated with clamped arithmetic.
// Build with MSRV32_BP_STATS_EN defined to also check the statistics ports.
module tb_msrv_32_branch_predictor;
  import msrv_32_pkg::*;

  localparam int ENTRIES = 64;
  localparam logic [4:0] OPC_OTHER = 5'b01100;

  logic clk_in = 1'b0;
  logic rst_n_in;

  always #5 clk_in = ~clk_in;

  msrv_32_branch_predictor_if bp_if ();

`ifdef MSRV32_BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  msrv_32_branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
`ifdef MSRV32_BP_STATS_EN
    .stat_branches_out    (stat_branches),
    .stat_mispredicts_out (stat_mispredicts),
`endif
    .bus                  (bp_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one integer 0..3 per entry plus event counts.
  int          model_ctr [ENTRIES];
  logic [31:0] model_branches;
  logic [31:0] model_mispredicts;
  logic        exp_valid;
  logic        exp_taken;
  logic        exp_misp;

  function automatic int idx_of(input logic [31:0] pc);
    logic [31:0] word;
    word = pc >> 2;
    return int'(word % 32'(ENTRIES));
  endfunction

  function automatic logic model_predict(input logic [4:0] opc, input int ctr);
    if (opc == OPC_JAL || opc == OPC_JALR) return 1'b1;
    if (opc == OPC_BRANCH) return (ctr >= 2);
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) model_ctr[i] = 1;
    model_branches    = 32'd0;
    model_mispredicts = 32'd0;
    exp_valid = 1'b0;
    exp_taken = 1'b0;
    exp_misp  = 1'b0;
  endtask

  task automatic drive_idle();
    bp_if.lookup_valid_in         = 1'b0;
    bp_if.lookup_pc_in            = 32'd0;
    bp_if.lookup_opcode_6_to_2_in = 5'd0;
    bp_if.flush_in                = 1'b0;
    bp_if.upd_valid_in            = 1'b0;
    bp_if.upd_pc_in               = 32'd0;
    bp_if.upd_opcode_6_to_2_in    = 5'd0;
    bp_if.upd_taken_in            = 1'b0;
    bp_if.upd_pred_in             = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (bp_if.pred_valid_out === exp_valid) else begin
      errors++;
      $error("[TB] FAIL %s pred_valid observed=%0b expected=%0b", tag, bp_if.pred_valid_out, exp_valid);
    end
    checks++;
    assert (bp_if.pred_taken_out === exp_taken) else begin
      errors++;
      $error("[TB] FAIL %s pred_taken observed=%0b expected=%0b", tag, bp_if.pred_taken_out, exp_taken);
    end
    checks++;
    assert (bp_if.mispredict_out === exp_misp) else begin
      errors++;
      $error("[TB] FAIL %s mispredict observed=%0b expected=%0b", tag, bp_if.mispredict_out, exp_misp);
    end
`ifdef MSRV32_BP_STATS_EN
    checks++;
    assert (stat_branches === model_branches) else begin
      errors++;
      $error("[TB] FAIL %s stat_branches observed=%0d expected=%0d", tag, stat_branches, model_branches);
    end
    checks++;
    assert (stat_mispredicts === model_mispredicts) else begin
      errors++;
      $error("[TB] FAIL %s stat_mispredicts observed=%0d expected=%0d", tag, stat_mispredicts, model_mispredicts);
    end
`endif
  endtask

  // One clock cycle: drive both ports, predict the registered results from
  // the pre-update model, advance the model, then compare after the edge.
  // Called at posedge+1 and returns at the next posedge+1.
  task automatic applyStimulus(input string tag,
                               input logic lv, input logic [31:0] lpc, input logic [4:0] lop,
                               input logic fl,
                               input logic uv, input logic [31:0] upc, input logic [4:0] uop,
                               input logic ut, input logic up);
    int ui;
    bp_if.lookup_valid_in         = lv;
    bp_if.lookup_pc_in            = lpc;
    bp_if.lookup_opcode_6_to_2_in = lop;
    bp_if.flush_in                = fl;
    bp_if.upd_valid_in            = uv;
    bp_if.upd_pc_in               = upc;
    bp_if.upd_opcode_6_to_2_in    = uop;
    bp_if.upd_taken_in            = ut;
    bp_if.upd_pred_in             = up;
    exp_valid = lv & ~fl;
    exp_taken = exp_valid ? model_predict(lop, model_ctr[idx_of(lpc)]) : 1'b0;
    exp_misp  = uv & (ut != up);
    @(posedge clk_in);
    if (uv && uop == OPC_BRANCH) begin
      ui = idx_of(upc);
      if (ut) model_ctr[ui] = (model_ctr[ui] == 3) ? 3 : model_ctr[ui] + 1;
      else    model_ctr[ui] = (model_ctr[ui] == 0) ? 0 : model_ctr[ui] - 1;
      if (model_branches != 32'hFFFF_FFFF) model_branches = model_branches + 32'd1;
    end
    if (exp_misp && model_mispredicts != 32'hFFFF_FFFF)
      model_mispredicts = model_mispredicts + 32'd1;
    #1;
    checkOutput(tag);
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic [4:0] opc);
    applyStimulus(tag, 1'b1, pc, opc, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic update(input string tag, input logic [31:0] pc, input logic [4:0] opc,
                        input logic taken, input logic pred);
    applyStimulus(tag, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1, pc, opc, taken, pred);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [4:0] opc_pool [6];
    opc_pool[0] = OPC_BRANCH; opc_pool[1] = OPC_BRANCH; opc_pool[2] = OPC_JAL;
    opc_pool[3] = OPC_JALR;   opc_pool[4] = OPC_OTHER;  opc_pool[5] = 5'b00000;

    // Reset held from time zero; outputs must be low immediately.
    rst_n_in = 1'b0;
    drive_idle();
    model_reset();
    #2;
    checkOutput("reset_async");
    @(posedge clk_in);
    #1;
    checkOutput("reset_hold");
    rst_n_in = 1'b1;

    // Branch lookup straight after reset sees weak not-taken.
    $display("[TB] directed: first lookup");
    lookup("first_branch_0x100", 32'h100, OPC_BRANCH);
    idle("after_first_lookup");

    // Two taken trains to strong taken; three not-taken to strong NT; a
    // fourth saturates there.
    $display("[TB] directed: training and saturation");
    update("train_t1_0x100", 32'h100, OPC_BRANCH, 1'b1, 1'b0);
    update("train_t2_0x100", 32'h100, OPC_BRANCH, 1'b1, 1'b1);
    lookup("pred_after_2t", 32'h100, OPC_BRANCH);
    update("train_nt1_0x100", 32'h100, OPC_BRANCH, 1'b0, 1'b1);
    update("train_nt2_0x100", 32'h100, OPC_BRANCH, 1'b0, 1'b1);
    update("train_nt3_0x100", 32'h100, OPC_BRANCH, 1'b0, 1'b0);
    lookup("pred_after_3nt", 32'h100, OPC_BRANCH);
    update("train_nt4_0x100", 32'h100, OPC_BRANCH, 1'b0, 1'b0);

    // 0x200 aliases 0x100 in a 64-entry table (counter now 00).
    $display("[TB] directed: jumps");
    lookup("jal_0x200_ctr00", 32'h200, OPC_JAL);
    lookup("jalr_0x200_ctr00", 32'h200, OPC_JALR);
    lookup("other_0x200", 32'h200, OPC_OTHER);
    update("jal_update_0x200", 32'h200, OPC_JAL, 1'b1, 1'b1);
    update("jalr_update_0x200", 32'h200, OPC_JALR, 1'b1, 1'b1);
    update("one_taken_0x100", 32'h100, OPC_BRANCH, 1'b1, 1'b0);
    lookup("ctr_was_00", 32'h100, OPC_BRANCH);

    // Same-cycle lookup and update at one index: lookup sees old value.
    $display("[TB] directed: read-before-write");
    applyStimulus("rbw_same_cycle_0x104", 1'b1, 32'h104, OPC_BRANCH, 1'b0,
                  1'b1, 32'h104, OPC_BRANCH, 1'b1, 1'b0);
    lookup("rbw_next_lookup_0x104", 32'h104, OPC_BRANCH);

    // Mispredict pulse lasts exactly one cycle.
    $display("[TB] directed: mispredict");
    update("misp_pulse", 32'h108, OPC_BRANCH, 1'b1, 1'b0);
    idle("misp_cleared");
    update("misp_jal", 32'h10C, OPC_JAL, 1'b0, 1'b1);
    update("no_misp", 32'h10C, OPC_BRANCH, 1'b0, 1'b0);

    // Flush kills the coincident lookup but the table still trains.
    $display("[TB] directed: flush");
    applyStimulus("flush_with_lookup", 1'b1, 32'h110, OPC_JAL, 1'b1,
                  1'b1, 32'h110, OPC_BRANCH, 1'b1, 1'b0);
    lookup("after_flush_trained", 32'h110, OPC_BRANCH);

    // Randomized traffic over a few colliding indices.
    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      logic        lv, fl, uv, ut, up;
      logic [31:0] lpc, upc;
      logic [4:0]  lop, uop;
      lv  = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 7) == 0);
      uv  = 1'($urandom_range(0, 1));
      ut  = 1'($urandom_range(0, 1));
      up  = 1'($urandom_range(0, 1));
      lpc = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 3)) << 2);
      upc = ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 3)) << 2);
      lop = opc_pool[$urandom_range(0, 5)];
      uop = opc_pool[$urandom_range(0, 5)];
      applyStimulus("random", lv, lpc, lop, fl, uv, upc, uop, ut, up);
    end

    // Mid-stream reset: push 0x1FC to strong taken, then reset with a
    // lookup and update in flight.
    $display("[TB] directed: mid-stream reset");
    update("pre_reset_t1_0x1FC", 32'h1FC, OPC_BRANCH, 1'b1, 1'b0);
    update("pre_reset_t2_0x1FC", 32'h1FC, OPC_BRANCH, 1'b1, 1'b0);
    update("pre_reset_t3_0x100", 32'h100, OPC_BRANCH, 1'b1, 1'b0);
    update("pre_reset_t4_0x100", 32'h100, OPC_BRANCH, 1'b1, 1'b0);
    bp_if.lookup_valid_in         = 1'b1;
    bp_if.lookup_pc_in            = 32'h1FC;
    bp_if.lookup_opcode_6_to_2_in = OPC_JAL;
    bp_if.upd_valid_in            = 1'b1;
    bp_if.upd_pc_in               = 32'h1FC;
    bp_if.upd_opcode_6_to_2_in    = OPC_BRANCH;
    bp_if.upd_taken_in            = 1'b1;
    bp_if.upd_pred_in             = 1'b0;
    #3;
    rst_n_in = 1'b0;
    model_reset();
    #1;
    checkOutput("mid_reset_async");
    @(posedge clk_in);
    #1;
    checkOutput("mid_reset_hold");
    drive_idle();
    rst_n_in = 1'b1;
    idle("post_reset_no_valid");
    lookup("post_reset_0x100", 32'h100, OPC_BRANCH);
    lookup("post_reset_0x1FC", 32'h1FC, OPC_BRANCH);
    update("post_reset_t_0x1FC", 32'h1FC, OPC_BRANCH, 1'b1, 1'b0);
    update("post_reset_t_0x100", 32'h100, OPC_BRANCH, 1'b1, 1'b0);
    lookup("post_reset_was01_0x1FC", 32'h1FC, OPC_BRANCH);
    lookup("post_reset_was01_0x100", 32'h100, OPC_BRANCH);
    idle("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv_32_branch_predictor.md
MSRV_32_BRANCH_PREDICTOR -- requirements
Module: msrv_32_branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, number of BHT entries (power of 2, 4..1024).
REQ-002 SHALL have derived constant IDX_W = log2(ENTRIES), table index width.
REQ-003 SHALL have port clk_in, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n_in, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port lookup_valid_in, input, 1, fetch lookup request this cycle.
REQ-006 SHALL have port lookup_pc_in, input, 32, PC of the fetched instruction.
REQ-007 SHALL have port lookup_opcode_6_to_2_in, input, 5, opcode[6:2] of the fetched instruction.
REQ-008 SHALL have port flush_in, input, 1, kill an in-flight prediction.
REQ-009 SHALL have port pred_valid_out, output, 1, prediction is valid.
REQ-010 SHALL have port pred_taken_out, output, 1, predicted direction.
REQ-011 SHALL have port upd_valid_in, input, 1, resolved branch report from the branch unit.
REQ-012 SHALL have port upd_pc_in, input, 32, PC of the resolved instruction.
REQ-013 SHALL have port upd_opcode_6_to_2_in, input, 5, opcode[6:2] of the resolved instruction.
REQ-014 SHALL have port upd_taken_in, input, 1, actual outcome (branch unit branch_taken_out).
REQ-015 SHALL have port upd_pred_in, input, 1, prediction that was issued for that instruction.
REQ-016 SHALL have port mispredict_out, output, 1, registered mispredict pulse.

Function
REQ-017 SHALL index the table with pc[IDX_W+1:2] on both ports; pc[1:0] ignored.
REQ-018 SHALL hold ENTRIES 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-019 SHALL register the prediction with 1-cycle latency: pred_valid_out = lookup_valid_in of the previous cycle, unless flush_in was high in that cycle.
REQ-020 SHALL compute pred_taken_out as: opcode 11011 (JAL) or 11001 (JALR) -> 1; opcode 11000 (BRANCH) -> counter[1]; any other opcode -> 0.
REQ-021 SHALL drive pred_taken_out to 0 whenever pred_valid_out is 0.
REQ-022 SHALL update a counter only when upd_valid_in=1 and upd_opcode_6_to_2_in=11000: taken -> +1, saturating at 11; not-taken -> -1, saturating at 00.
REQ-023 SHALL leave the table unchanged for JAL/JALR/other-opcode updates.
REQ-024 SHALL pulse mispredict_out high for exactly the cycle after an update with upd_valid_in=1 and upd_taken_in != upd_pred_in, for any opcode.
REQ-025 SHALL give the lookup the pre-update counter value when a lookup and an update hit the same index in the same cycle (read-before-write, no bypass).
REQ-026 SHALL accept a new lookup and a new update every cycle (no stall, no backpressure).
REQ-027 SHALL drop the output of the lookup issued in the flush cycle when flush_in=1 and lookup_valid_in=1 coincide; the table SHALL still accept updates during flush.

Reset
REQ-028 SHALL, while rst_n_in=0, immediately set all counters to 01, pred_valid_out=0, pred_taken_out=0, mispredict_out=0.
REQ-029 SHALL discard any in-flight lookup or update on reset assertion mid-operation; the first valid prediction appears one cycle after the first lookup following deassertion.

Configuration
REQ-030 SHALL, with MSRV32_BP_STATS_EN defined, add outputs stat_branches_out[31:0] and stat_mispredicts_out[31:0], counting conditional-branch updates and mispredicting updates, saturating at FFFFFFFF and reset to 0.
REQ-031 SHALL, without MSRV32_BP_STATS_EN, omit those ports and counters entirely.

Structure
REQ-032 SHALL take opcode constants (BRANCH 11000, JAL 11011, JALR 11001) and the counter encodings from shared package msrv_32_pkg, which the branch unit also uses.
REQ-033 SHALL implement counter next-state in sub-module msrv_32_sat_counter2 (2-bit state, taken in, next state out).

Verification
REQ-034 SHALL cover reset then lookup of BRANCH at PC 0x100 -> pred_valid_out=1, pred_taken_out=0 one cycle later.
REQ-035 SHALL cover two taken updates at PC 0x100 then a lookup -> pred_taken_out=1; three further not-taken updates -> 0, and the counter reads 00 after a fourth.
REQ-036 SHALL cover JAL lookup at PC 0x200 with counter 00 -> pred_taken_out=1, and a JAL update leaves the counter unchanged.
REQ-037 SHALL cover same-cycle lookup and taken-update at PC 0x104 (counter 01) -> pred_taken_out=0, and the next lookup -> 1.
REQ-038 SHALL cover update with upd_taken_in=1 and upd_pred_in=0 -> one-cycle mispredict_out pulse; with the macro on, stat_mispredicts_out increments by 1.
REQ-039 SHALL cover flush_in together with lookup, and rst_n_in low mid-stream -> no pred_valid_out, and all entries read 01 afterwards (PCs 0x100 and 0x1FC, ENTRIES=64).
